// File: rtl/cpu_log_pkg.sv
// Shared types and constants for the CPU log record extractor.
// Holds format_type encodings, parser state encodings, record layout
// constants, the ASCII delimiters of a log line and character helpers.
package cpu_log_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned FT_W   = 2;

    typedef enum logic [1:0] {
        FT_NONE = 2'd0,
        FT_REG  = 2'd1,
        FT_MEM  = 2'd2
    } format_t;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0,
        P_TIME = 3'd1,
        P_PC   = 3'd2,
        P_SEP  = 3'd3,
        P_GRF  = 3'd4,
        P_ADDR = 3'd5,
        P_DATA = 3'd6
    } pstate_t;

    // Fixed-width part of a record; the time field width is a top-level parameter.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } rec_words_t;

    localparam int unsigned REC_FIXED_W = FT_W + $bits(rec_words_t);

    localparam logic [7:0] CH_CARET  = 8'h5E;  // '^'
    localparam logic [7:0] CH_AT     = 8'h40;  // '@'
    localparam logic [7:0] CH_COLON  = 8'h3A;  // ':'
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
    localparam logic [7:0] CH_STAR   = 8'h2A;  // '*'
    localparam logic [7:0] CH_EQ     = 8'h3D;  // '='
    localparam logic [7:0] CH_HASH   = 8'h23;  // '#'

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Lowercase hex only; uppercase letters are deliberately not digits.
    function automatic logic is_hex(input logic [7:0] c);
        return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // '0'-'9' carry their value in the low nibble; 'a'-'f' low nibble is 1..6.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return is_dec(c) ? c[3:0] : 4'(c[3:0] + 4'd9);
    endfunction

endpackage

// File: rtl/cpu_log_record_extractor_rec_fifo.sv
// rec_fifo: generic synchronous FIFO with a valid/ready read side.
// Ports: clk, reset (async active-low), push/push_data write side,
// head_valid/head_ready/head_data read side (head driven straight from
// storage), drop_c flags a push rejected because the FIFO is full.
// Pointers carry one extra wrap bit to tell full from empty.
module rec_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             head_valid,
    input  logic             head_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic empty_c;
    logic full_c;
    logic pop_c;
    logic wr_en_c;

    // Full: same slot index, opposite lap.
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_c   = !empty_c && head_ready;
    // A pop in the same cycle frees the slot the write lands in.
    assign wr_en_c = push && (!full_c || pop_c);
    assign drop_c  = push && full_c && !pop_c;

    assign head_valid = !empty_c;
    assign head_data  = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/cpu_log_record_extractor.sv
// cpu_log_record_extractor: parses the cpu_checker character stream into
// time/PC/address/data fields and queues one record per valid line.
// Ports: clk, reset (async active-low), char (stream byte), format_type
// (checker verdict, nonzero for one cycle after '#'), rec_valid/rec_ready
// record handshake, rec_type/rec_time/rec_pc/rec_addr/rec_data head record,
// overflow (sticky drop flag).
// Optional: define CPU_REC_DROP_CNT_EN to add drop_cnt[7:0], a saturating
// count of dropped records.
module cpu_log_record_extractor
    import cpu_log_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TIME_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char,
    input  logic [1:0]        format_type,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [1:0]        rec_type,
    output logic [TIME_W-1:0] rec_time,
    output logic [31:0]       rec_pc,
    output logic [31:0]       rec_addr,
    output logic [31:0]       rec_data,
`ifdef CPU_REC_DROP_CNT_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic              overflow
);

    localparam int unsigned REC_W = REC_FIXED_W + TIME_W;
    localparam logic [TIME_W-1:0] TEN_T = TIME_W'(10);
    localparam logic [31:0]       TEN_W = 32'd10;

    pstate_t           state;
    logic [TIME_W-1:0] time_acc;
    logic [31:0]       pc_acc;
    logic [31:0]       addr_acc;
    logic [31:0]       data_acc;

    logic       dec_c;
    logic       hex_c;
    logic [3:0] nib_c;

    assign dec_c = is_dec(char);
    assign hex_c = is_hex(char);
    assign nib_c = hex_val(char);

    // Field parser; '^' restarts a line from any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= P_IDLE;
            time_acc <= '0;
            pc_acc   <= '0;
            addr_acc <= '0;
            data_acc <= '0;
        end else if (char == CH_CARET) begin
            state    <= P_TIME;
            time_acc <= '0;
            pc_acc   <= '0;
            addr_acc <= '0;
            data_acc <= '0;
        end else begin
            case (state)
                P_TIME: begin
                    if (char == CH_AT)  state    <= P_PC;
                    else if (dec_c)     time_acc <= time_acc * TEN_T + TIME_W'(nib_c);
                end
                P_PC: begin
                    if (char == CH_COLON) state  <= P_SEP;
                    else if (hex_c)       pc_acc <= {pc_acc[27:0], nib_c};
                end
                P_SEP: begin
                    if (char == CH_DOLLAR)    state <= P_GRF;
                    else if (char == CH_STAR) state <= P_ADDR;
                end
                P_GRF: begin
                    if (char == CH_EQ) state    <= P_DATA;
                    else if (dec_c)    addr_acc <= addr_acc * TEN_W + 32'(nib_c);
                end
                P_ADDR: begin
                    if (char == CH_EQ) state    <= P_DATA;
                    else if (hex_c)    addr_acc <= {addr_acc[27:0], nib_c};
                end
                P_DATA: begin
                    if (hex_c) data_acc <= {data_acc[27:0], nib_c};
                end
                default: ;
            endcase
        end
    end

    // Push uses the pre-edge accumulators, so a '^' in the push cycle is safe.
    logic             push_c;
    logic [REC_W-1:0] push_data_c;
    logic [REC_W-1:0] head_data;
    logic             drop_c;
    rec_words_t       push_words_c;
    rec_words_t       head_words;

    assign push_c             = (format_type != FT_NONE);
    assign push_words_c.pc    = pc_acc;
    assign push_words_c.addr  = addr_acc;
    assign push_words_c.data  = data_acc;
    assign push_data_c        = {format_type, time_acc, push_words_c};

    rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_rec_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_c),
        .push_data  (push_data_c),
        .head_valid (rec_valid),
        .head_ready (rec_ready),
        .head_data  (head_data),
        .drop_c     (drop_c)
    );

    assign {rec_type, rec_time, head_words} = head_data;
    assign rec_pc   = head_words.pc;
    assign rec_addr = head_words.addr;
    assign rec_data = head_words.data;

    // Sticky drop indication.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end
    end

`ifdef CPU_REC_DROP_CNT_EN
    // Saturating dropped-record counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop_c && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_log_record_extractor.sv
// Directed bench for cpu_log_record_extractor (DEPTH=4, TIME_W=16).
module tb_cpu_log_record_extractor;

    logic        clk;
    logic        reset;
    logic [7:0]  ch;
    logic [1:0]  ft;
    logic        rec_valid;
    logic        rec_ready;
    logic [1:0]  rec_type;
    logic [15:0] rec_time;
    logic [31:0] rec_pc;
    logic [31:0] rec_addr;
    logic [31:0] rec_data;
    logic        overflow;
`ifdef CPU_REC_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    cpu_log_record_extractor #(.DEPTH(4), .TIME_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .char        (ch),
        .format_type (ft),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_type    (rec_type),
        .rec_time    (rec_time),
        .rec_pc      (rec_pc),
        .rec_addr    (rec_addr),
        .rec_data    (rec_data),
`ifdef CPU_REC_DROP_CNT_EN
        .drop_cnt    (drop_cnt),
`endif
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one character per cycle, inputs changed on the falling edge.
    task automatic send_chars(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
            ft = 2'd0;
        end
    endtask

    // Cycle after '#': checker verdict plus a trailing char; optional pop.
    task automatic push_rec(input logic [1:0] f, input logic [7:0] trail, input logic pop_too);
        @(negedge clk);
        ch        = trail;
        ft        = f;
        rec_ready = pop_too;
        @(negedge clk);
        ch        = 8'h00;
        ft        = 2'd0;
        rec_ready = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
    endtask

    task automatic reg_line(input int t);
        send_chars($sformatf("^%0d@%08x: $%0d <= %08x#", t, t, t, t));
        push_rec(2'd1, "x", 1'b0);
    endtask

    task automatic chk_head(input string tag, input logic [1:0] ty, input logic [15:0] t,
                            input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_valid"}, rec_valid, 1);
        chk({tag, "_type"},  rec_type,  ty);
        chk({tag, "_time"},  rec_time,  t);
        chk({tag, "_pc"},    rec_pc,    pc);
        chk({tag, "_addr"},  rec_addr,  a);
        chk({tag, "_data"},  rec_data,  d);
    endtask

    initial begin
        reset     = 1'b0;
        ch        = 8'h00;
        ft        = 2'd0;
        rec_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", rec_valid, 0);
        chk("rst_type",  rec_type,  0);
        chk("rst_time",  rec_time,  0);
        chk("rst_data",  rec_data,  0);
        chk("rst_ovf",   overflow,  0);
`ifdef CPU_REC_DROP_CNT_EN
        chk("rst_dcnt",  drop_cnt,  0);
`endif
        reset = 1'b1;

        // Register write record, with latency check.
        send_chars("^1234@00003000: $5 <= 0000abcd#");
        @(negedge clk);
        chk("lat_no_rec_yet", rec_valid, 0);
        ch = "x";
        ft = 2'd1;
        @(negedge clk);
        ch = 8'h00;
        ft = 2'd0;
        chk_head("reg", 2'd1, 16'd1234, 32'h0000_3000, 32'd5, 32'h0000_abcd);
        @(negedge clk);
        chk("reg_hold_time", rec_time, 16'd1234);
        pop_one();
        chk("reg_popped", rec_valid, 0);

        // Memory write record.
        send_chars("^7@0000300c: *00001004 <= deadbeef#");
        push_rec(2'd2, "x", 1'b0);
        chk_head("mem", 2'd2, 16'd7, 32'h0000_300c, 32'h0000_1004, 32'hdead_beef);
        pop_one();
        chk("mem_popped", rec_valid, 0);

        // Back-to-back: next line's '^' arrives in the push cycle.
        send_chars("^3@00000010: $7 <= 00000001#");
        push_rec(2'd1, "^", 1'b0);
        send_chars("9@00000020: $2 <= 00000002#");
        push_rec(2'd1, "x", 1'b0);
        chk_head("b2b_a", 2'd1, 16'd3, 32'h10, 32'd7, 32'd1);
        pop_one();
        chk_head("b2b_b", 2'd1, 16'd9, 32'h20, 32'd2, 32'd2);
        pop_one();
        chk("b2b_empty", rec_valid, 0);

        // Full FIFO with a pop in the push cycle: nothing dropped.
        for (int t = 11; t <= 14; t++) reg_line(t);
        send_chars("^15@0000000f: $15 <= 0000000f#");
        push_rec(2'd1, "x", 1'b1);
        chk("fullpop_ovf", overflow, 0);
        for (int t = 12; t <= 15; t++) begin
            chk_head($sformatf("fullpop_%0d", t), 2'd1, 16'(t), 32'(t), 32'(t), 32'(t));
            pop_one();
        end
        chk("fullpop_empty", rec_valid, 0);

        // Backpressure: fifth record dropped.
        for (int t = 21; t <= 24; t++) reg_line(t);
        chk("bp_ovf_before", overflow, 0);
        reg_line(25);
        chk("bp_ovf_after", overflow, 1);
`ifdef CPU_REC_DROP_CNT_EN
        chk("bp_dcnt", drop_cnt, 1);
`endif
        for (int t = 21; t <= 24; t++) begin
            chk_head($sformatf("bp_%0d", t), 2'd1, 16'(t), 32'(t), 32'(t), 32'(t));
            pop_one();
        end
        chk("bp_empty", rec_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);

        // Reset mid-line with a record queued.
        reg_line(5);
        chk("rml_queued", rec_valid, 1);
        send_chars("^12@0000");
        #2;
        reset = 1'b0;
        #1;
        chk("rml_valid_async", rec_valid, 0);
        chk("rml_ovf_clr", overflow, 0);
`ifdef CPU_REC_DROP_CNT_EN
        chk("rml_dcnt_clr", drop_cnt, 0);
`endif
        @(negedge clk);
        ch    = 8'h00;
        reset = 1'b1;
        send_chars("^34@0000abcd: *00000100 <= 12345678#");
        push_rec(2'd2, "x", 1'b0);
        chk_head("rml_fresh", 2'd2, 16'd34, 32'h0000_abcd, 32'h0000_0100, 32'h1234_5678);
        pop_one();
        chk("rml_empty", rec_valid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
